// File: rtl/mm_port_arbiter_if.sv
// Bundle between NUM_MASTERS bus agents, the port arbiter and one memory-mapped slave.
// The slave modport is the arbiter's view; the master modport is the agents' and peripheral's view.
interface mm_port_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic [NUM_MASTERS-1:0]            m_read;
  logic [NUM_MASTERS-1:0]            m_write;
  logic [NUM_MASTERS*BE_W-1:0]       m_byte_enable;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_write_data;
  logic [NUM_MASTERS-1:0]            m_ack;
  logic [NUM_MASTERS-1:0]            m_read_valid;
  logic [DATA_WIDTH-1:0]             m_read_data;

  logic                              s_read_enable;
  logic                              s_write_enable;
  logic [BE_W-1:0]                   s_write_byte_enable;
  logic [ADDR_WIDTH-1:0]             s_address;
  logic [DATA_WIDTH-1:0]             s_write_data;
  logic [DATA_WIDTH-1:0]             s_read_data;

  modport slave (
    input  m_read, m_write, m_byte_enable, m_address, m_write_data, s_read_data,
    output m_ack, m_read_valid, m_read_data,
           s_read_enable, s_write_enable, s_write_byte_enable, s_address, s_write_data
  );

  modport master (
    output m_read, m_write, m_byte_enable, m_address, m_write_data, s_read_data,
    input  m_ack, m_read_valid, m_read_data,
           s_read_enable, s_write_enable, s_write_byte_enable, s_address, s_write_data
  );
endinterface

// File: rtl/mm_port_arbiter.sv
// Round-robin arbiter sharing one memory-mapped slave port among NUM_MASTERS requesters.
// Registers the winning command, acks it in the same cycle it drives the slave, and routes read data back.
module mm_port_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic               clock,
  input  logic               reset,
  mm_port_arbiter_if.slave   bus
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0] ONE      = NUM_MASTERS'(1);

  typedef struct packed {
    logic                  rd;
    logic                  wr;
    logic [BE_W-1:0]       be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } cmd_t;

  cmd_t             cmd_q, cmd_d;
  logic             issue_valid_q, issue_valid_d;
  logic [IDX_W-1:0] issue_idx_q, issue_idx_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic             rd_pending_q, rd_pending_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;

  logic [NUM_MASTERS-1:0] elig;
  logic                   found;
  logic [IDX_W-1:0]       win;

  // The master on the slave port still holds its request during its ack cycle; mask it.
  always_comb begin
    elig = bus.m_read | bus.m_write;
    if (issue_valid_q) elig[issue_idx_q] = 1'b0;
  end

  always_comb begin
    int cand;
    found = 1'b0;
    win   = last_grant_q;
    cand  = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = int'(last_grant_q) + k;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      if (!found && elig[IDX_W'(cand)]) begin
        found = 1'b1;
        win   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    cmd_d         = '0;
    issue_valid_d = found;
    issue_idx_d   = win;
    last_grant_d  = win;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (found && win == IDX_W'(i)) begin
        cmd_d.rd   = bus.m_read[i];
        cmd_d.wr   = bus.m_write[i];
        cmd_d.be   = bus.m_byte_enable[i*BE_W +: BE_W];
        cmd_d.addr = bus.m_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        cmd_d.data = bus.m_write_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    rd_pending_d = issue_valid_q & cmd_q.rd;
    rd_idx_d     = issue_idx_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_q         <= '0;
      issue_valid_q <= 1'b0;
      issue_idx_q   <= '0;
      last_grant_q  <= LAST_IDX;
      rd_pending_q  <= 1'b0;
      rd_idx_q      <= '0;
    end else begin
      cmd_q         <= cmd_d;
      issue_valid_q <= issue_valid_d;
      issue_idx_q   <= issue_idx_d;
      last_grant_q  <= last_grant_d;
      rd_pending_q  <= rd_pending_d;
      rd_idx_q      <= rd_idx_d;
    end
  end

  assign bus.m_ack               = issue_valid_q ? (ONE << issue_idx_q) : '0;
  assign bus.m_read_valid        = rd_pending_q  ? (ONE << rd_idx_q)    : '0;
  assign bus.m_read_data         = rd_pending_q  ? bus.s_read_data      : '0;
  assign bus.s_read_enable       = cmd_q.rd;
  assign bus.s_write_enable      = cmd_q.wr;
  assign bus.s_write_byte_enable = cmd_q.be;
  assign bus.s_address           = cmd_q.addr;
  assign bus.s_write_data        = cmd_q.data;
endmodule

// File: tb/tb_mm_port_arbiter.sv
// Bench for mm_port_arbiter with three masters: directed scenarios then random traffic,
// each cycle checked against a transaction-level model of grants, slave commands and read returns.
module tb_mm_port_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int BW = DW / 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mm_port_arbiter_if #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mm_port_arbiter #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Peripheral: registered read, returns zero when not reading, read-before-write.
  logic [DW-1:0] smem [256] = '{default: '0};
  always @(posedge clock) begin
    bus.s_read_data <= bus.s_read_enable ? smem[bus.s_address] : '0;
    if (bus.s_write_enable)
      for (int b = 0; b < BW; b++)
        if (bus.s_write_byte_enable[b]) smem[bus.s_address][8*b +: 8] <= bus.s_write_data[8*b +: 8];
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [256] = '{default: '0};
  int            m_last, m_inflight, pend_idx;
  logic [DW-1:0] pend_data;
  int            wait_cnt [N];
  logic [N-1:0]  e_ack, e_rv;
  logic [DW-1:0] e_rdata, e_wdata;
  logic          e_re, e_we;
  logic [BW-1:0] e_be;
  logic [AW-1:0] e_addr;
  bit            acked_prev [N];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic set_cmd(input int i, input bit r, input bit w, input logic [BW-1:0] be,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.m_read[i]                    = r;
    bus.m_write[i]                   = w;
    bus.m_byte_enable[i*BW +: BW]    = be;
    bus.m_address[i*AW +: AW]        = a;
    bus.m_write_data[i*DW +: DW]     = d;
  endtask

  task automatic clr(input int i);
    set_cmd(i, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Advance one clock, predict the registered outputs from the inputs held last cycle, compare.
  task automatic step();
    logic [N-1:0] req;
    int win, max_wait;
    @(posedge clock);
    #1;
    req = bus.m_read | bus.m_write;
    if (reset) begin
      m_last = N - 1; m_inflight = -1; pend_idx = -1;
      e_ack = '0; e_rv = '0; e_rdata = '0; e_re = 1'b0; e_we = 1'b0;
      e_be = '0; e_addr = '0; e_wdata = '0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else begin
      e_rv    = (pend_idx >= 0) ? (N'(1) << pend_idx) : '0;
      e_rdata = (pend_idx >= 0) ? pend_data : '0;
      win = -1;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (win < 0 && req[c] && c != m_inflight) win = c;
      end
      if (win >= 0) begin
        e_ack   = N'(1) << win;
        e_re    = bus.m_read[win];
        e_we    = bus.m_write[win];
        e_be    = bus.m_byte_enable[win*BW +: BW];
        e_addr  = bus.m_address[win*AW +: AW];
        e_wdata = bus.m_write_data[win*DW +: DW];
        pend_idx  = e_re ? win : -1;
        pend_data = ref_mem[e_addr];
        if (e_we)
          for (int b = 0; b < BW; b++)
            if (e_be[b]) ref_mem[e_addr][8*b +: 8] = e_wdata[8*b +: 8];
        for (int i = 0; i < N; i++)
          if (i == win) wait_cnt[i] = 0;
          else if (req[i]) wait_cnt[i]++;
        m_last = win; m_inflight = win;
      end else begin
        e_ack = '0; e_re = 1'b0; e_we = 1'b0; e_be = '0; e_addr = '0; e_wdata = '0;
        pend_idx = -1; m_inflight = -1;
      end
      for (int i = 0; i < N; i++) if (!req[i]) wait_cnt[i] = 0;
    end
    max_wait = 0;
    for (int i = 0; i < N; i++) if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    chk("m_ack",        32'(bus.m_ack),               32'(e_ack));
    chk("m_read_valid", 32'(bus.m_read_valid),        32'(e_rv));
    chk("m_read_data",  32'(bus.m_read_data),         32'(e_rdata));
    chk("s_read_en",    32'(bus.s_read_enable),       32'(e_re));
    chk("s_write_en",   32'(bus.s_write_enable),      32'(e_we));
    chk("s_byte_en",    32'(bus.s_write_byte_enable), 32'(e_be));
    chk("s_address",    32'(bus.s_address),           32'(e_addr));
    chk("s_write_data", 32'(bus.s_write_data),        32'(e_wdata));
    chk("fair_wait",    32'(max_wait <= N - 1),       32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) clr(i);
    step();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) clr(i);
    reset = 1'b1;
    step();
    step();
    chk("rst_ack", 32'(bus.m_ack), 32'd0);
    chk("rst_sre", 32'(bus.s_read_enable), 32'd0);
    reset = 1'b0;

    // Single read (address preloaded by a write from the same master).
    set_cmd(0, 1'b0, 1'b1, 4'hF, 8'h04, 32'hDEADBEEF);
    step();
    chk("t1_wr_ack", 32'(bus.m_ack), 32'd1);
    step();
    set_cmd(0, 1'b1, 1'b0, 4'h0, 8'h04, 32'h0);
    step();
    chk("t1_ack", 32'(bus.m_ack), 32'd1);
    chk("t1_sre", 32'(bus.s_read_enable), 32'd1);
    chk("t1_addr", 32'(bus.s_address), 32'h04);
    step();
    chk("t1_rv", 32'(bus.m_read_valid), 32'd1);
    chk("t1_rdata", bus.m_read_data, 32'hDEADBEEF);
    clr(0);

    // Two masters writing continuously alternate with no idle slave cycle.
    do_reset();
    set_cmd(0, 1'b0, 1'b1, 4'hF, 8'h00, 32'h11111111);
    set_cmd(1, 1'b0, 1'b1, 4'hF, 8'h01, 32'h22222222);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t2_ack", 32'(bus.m_ack), (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("t2_we", 32'(bus.s_write_enable), 32'd1);
      chk("t2_wd", bus.s_write_data, (k % 2 == 0) ? 32'h11111111 : 32'h22222222);
    end

    // A lone streaming master is issued every other cycle.
    do_reset();
    set_cmd(1, 1'b0, 1'b1, 4'hF, 8'h10, 32'h33330000);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t3_ack", 32'(bus.m_ack), (k % 2 == 0) ? 32'd2 : 32'd0);
      chk("t3_we", 32'(bus.s_write_enable), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    clr(1);

    // Byte enables pass through.
    do_reset();
    set_cmd(1, 1'b0, 1'b1, 4'b0100, 8'h03, 32'hAABBCCDD);
    step();
    chk("t4_ack", 32'(bus.m_ack), 32'd2);
    chk("t4_be", 32'(bus.s_write_byte_enable), 32'h4);
    chk("t4_wd", bus.s_write_data, 32'hAABBCCDD);
    step();
    clr(1);

    // Read/write interleave across three masters.
    do_reset();
    set_cmd(2, 1'b1, 1'b0, 4'h0, 8'h04, 32'h0);
    set_cmd(0, 1'b0, 1'b1, 4'hF, 8'h06, 32'h600DF00D);
    step();
    chk("t5_ack0", 32'(bus.m_ack), 32'd1);
    chk("t5_rv0", 32'(bus.m_read_valid), 32'd0);
    step();
    chk("t5_ack2", 32'(bus.m_ack), 32'd4);
    chk("t5_sre", 32'(bus.s_read_enable), 32'd1);
    chk("t5_rv1", 32'(bus.m_read_valid), 32'd0);
    clr(0);
    step();
    chk("t5_rv2", 32'(bus.m_read_valid), 32'd4);
    chk("t5_rdata", bus.m_read_data, 32'hDEADBEEF);
    clr(2);
    step();
    chk("t5_rv3", 32'(bus.m_read_valid), 32'd0);
    chk("t5_rdata0", bus.m_read_data, 32'd0);

    // Reset while a read is on the slave port drops its return.
    do_reset();
    set_cmd(1, 1'b1, 1'b0, 4'h0, 8'h04, 32'h0);
    step();
    chk("t6_sre", 32'(bus.s_read_enable), 32'd1);
    reset = 1'b1;
    clr(1);
    step();
    chk("t6_rv", 32'(bus.m_read_valid), 32'd0);
    chk("t6_sre0", 32'(bus.s_read_enable), 32'd0);
    chk("t6_addr0", 32'(bus.s_address), 32'd0);
    reset = 1'b0;
    set_cmd(0, 1'b1, 1'b0, 4'h0, 8'h05, 32'h0);
    set_cmd(1, 1'b1, 1'b0, 4'h0, 8'h06, 32'h0);
    step();
    chk("t6_first", 32'(bus.m_ack), 32'd1);

    // Random traffic: hold until ack, change only after the ack cycle, occasional withdraw/reset.
    for (int i = 0; i < N; i++) acked_prev[i] = e_ack[i];
    for (int cyc = 0; cyc < 800; cyc++) begin
      step();
      reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        if (e_ack[i]) begin
          // request stays up through its own ack cycle
        end else if (acked_prev[i] || !(bus.m_read[i] | bus.m_write[i])) begin
          if ($urandom_range(0, 9) < 6) begin
            int kind;
            kind = $urandom_range(0, 4);
            set_cmd(i, kind != 2 && kind != 3, kind >= 2, 4'($urandom),
                    8'($urandom_range(0, 15)), $urandom);
          end else clr(i);
        end else if ($urandom_range(0, 19) == 0) clr(i);
        acked_prev[i] = e_ack[i];
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
